// File: rtl/apll_reset_seq.sv
// Reset/lock sequencer for the 50->60 MHz altera_pll: pulses pll_rst, qualifies lock, releases sys_rst_n.
// Define APLL_LOSS_CNT_EN to add the loss_cnt[7:0] lock-loss counter output.
module apll_reset_seq #(
  parameter int RST_CYCLES    = 32,
  parameter int LOCK_TIMEOUT  = 500000,
  parameter int STABLE_CYCLES = 1024,
  parameter int MAX_RETRY     = 3,
  parameter int CW            = 20
) (
  input  logic       refclk,
  input  logic       rst_n,
  input  logic       pll_locked,
  input  logic       soft_rst,
  output logic       pll_rst,
  output logic       sys_rst_n,
  output logic       ready,
  output logic       fail,
  output logic [3:0] retry_cnt
`ifdef APLL_LOSS_CNT_EN
  ,
  output logic [7:0] loss_cnt
`endif
);

  typedef enum logic [2:0] {
    ST_PLL_RST   = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_STABLE    = 3'd2,
    ST_RUN       = 3'd3,
    ST_FAIL      = 3'd4
  } state_e;

  localparam logic [CW-1:0] C_RST_LAST    = CW'(RST_CYCLES - 1);
  localparam logic [CW-1:0] C_LOCK_LAST   = CW'(LOCK_TIMEOUT - 1);
  localparam logic [CW-1:0] C_STABLE_LAST = CW'(STABLE_CYCLES - 1);
  localparam logic [CW-1:0] C_CNT_MAX     = {CW{1'b1}};
  localparam logic [3:0]    C_MAX_RETRY   = 4'(MAX_RETRY);

  state_e        r_state;
  logic [CW-1:0] r_cnt;
  logic          r_sync1;
  logic          r_lk;
  logic          r_pll_rst;
  logic          r_run;
  logic          r_fail;
  logic [3:0]    r_retry;
  logic [CW-1:0] w_cnt_inc;
  logic [3:0]    w_retry_inc;

  // Saturating increments: the shared counter and the retry count never wrap.
  always_comb begin
    w_cnt_inc   = r_cnt;
    w_retry_inc = r_retry;
    if (r_cnt != C_CNT_MAX) begin
      w_cnt_inc = r_cnt + CW'(1);
    end else begin
      w_cnt_inc = r_cnt;
    end
    if (r_retry != 4'hF) begin
      w_retry_inc = r_retry + 4'd1;
    end else begin
      w_retry_inc = r_retry;
    end
  end

  // Two-flop synchronizer bringing the asynchronous lock indication onto refclk.
  always_ff @(posedge refclk) begin
    if (!rst_n) begin
      r_sync1 <= 1'b0;
      r_lk    <= 1'b0;
    end else begin
      r_sync1 <= pll_locked;
      r_lk    <= r_sync1;
    end
  end

  // Sequencer FSM; outputs are registered and updated on the same edge as the state.
  always_ff @(posedge refclk) begin
    if (!rst_n) begin
      r_state   <= ST_PLL_RST;
      r_cnt     <= '0;
      r_pll_rst <= 1'b1;
      r_run     <= 1'b0;
      r_fail    <= 1'b0;
      r_retry   <= 4'd0;
    end else if (soft_rst) begin
      r_state   <= ST_PLL_RST;
      r_cnt     <= '0;
      r_pll_rst <= 1'b1;
      r_run     <= 1'b0;
      r_fail    <= 1'b0;
      r_retry   <= 4'd0;
    end else begin
      case (r_state)
        ST_PLL_RST: begin
          if (r_cnt == C_RST_LAST) begin
            r_state   <= ST_WAIT_LOCK;
            r_cnt     <= '0;
            r_pll_rst <= 1'b0;
          end else begin
            r_cnt <= w_cnt_inc;
          end
        end
        ST_WAIT_LOCK: begin
          if (r_lk) begin
            r_state <= ST_STABLE;
            r_cnt   <= '0;
          end else if (r_cnt == C_LOCK_LAST) begin
            r_retry <= w_retry_inc;
            r_cnt   <= '0;
            if (w_retry_inc == C_MAX_RETRY) begin
              r_state <= ST_FAIL;
              r_fail  <= 1'b1;
            end else begin
              r_state   <= ST_PLL_RST;
              r_pll_rst <= 1'b1;
            end
          end else begin
            r_cnt <= w_cnt_inc;
          end
        end
        ST_STABLE: begin
          // A lock drop here is a glitch, not a timeout: requalify without counting a retry.
          if (!r_lk) begin
            r_state <= ST_WAIT_LOCK;
            r_cnt   <= '0;
          end else if (r_cnt == C_STABLE_LAST) begin
            r_state <= ST_RUN;
            r_cnt   <= '0;
            r_retry <= 4'd0;
            r_run   <= 1'b1;
          end else begin
            r_cnt <= w_cnt_inc;
          end
        end
        ST_RUN: begin
          if (!r_lk) begin
            r_state   <= ST_PLL_RST;
            r_cnt     <= '0;
            r_pll_rst <= 1'b1;
            r_run     <= 1'b0;
          end else begin
            r_run <= 1'b1;
          end
        end
        ST_FAIL: begin
          r_pll_rst <= 1'b0;
          r_run     <= 1'b0;
          r_fail    <= 1'b1;
        end
        default: begin
          r_state   <= ST_PLL_RST;
          r_cnt     <= '0;
          r_pll_rst <= 1'b1;
          r_run     <= 1'b0;
        end
      endcase
    end
  end

`ifdef APLL_LOSS_CNT_EN
  logic [7:0] r_loss;

  // Counts lock losses out of RUN; soft_rst does not count and does not clear it.
  always_ff @(posedge refclk) begin
    if (!rst_n) begin
      r_loss <= 8'd0;
    end else if (!soft_rst && (r_state == ST_RUN) && !r_lk && (r_loss != 8'hFF)) begin
      r_loss <= r_loss + 8'd1;
    end else begin
      r_loss <= r_loss;
    end
  end

  assign loss_cnt = r_loss;
`endif

  assign pll_rst   = r_pll_rst;
  assign sys_rst_n = r_run;
  assign ready     = r_run;
  assign fail      = r_fail;
  assign retry_cnt = r_retry;

  apll_reset_seq_chk #(.MAX_RETRY(MAX_RETRY)) u_chk (
    .refclk    (refclk),
    .rst_n     (rst_n),
    .pll_rst   (r_pll_rst),
    .sys_rst_n (r_run),
    .ready     (r_run),
    .fail      (r_fail),
    .retry_cnt (r_retry)
  );

endmodule

// Invariants of the sequencer outputs.
module apll_reset_seq_chk #(
  parameter int MAX_RETRY = 3
) (
  input logic       refclk,
  input logic       rst_n,
  input logic       pll_rst,
  input logic       sys_rst_n,
  input logic       ready,
  input logic       fail,
  input logic [3:0] retry_cnt
);

  a_ready_eq_sys: assert property (@(posedge refclk) disable iff (!rst_n)
    ready == sys_rst_n);

  a_fail_quiet: assert property (@(posedge refclk) disable iff (!rst_n)
    fail |-> (!pll_rst && !sys_rst_n));

  a_retry_bound: assert property (@(posedge refclk) disable iff (!rst_n)
    retry_cnt <= 4'(MAX_RETRY));

endmodule

// File: tb/tb_apll_reset_seq.sv
// Self-checking bench for apll_reset_seq: directed table, corner sequences, and random stimulus vs a phase model.
module tb_apll_reset_seq;

  localparam int RST_CYCLES    = 4;
  localparam int LOCK_TIMEOUT  = 16;
  localparam int STABLE_CYCLES = 8;
  localparam int MAX_RETRY     = 3;

  logic       refclk = 1'b0;
  logic       rst_n = 1'b0;
  logic       pll_locked = 1'b0;
  logic       soft_rst = 1'b0;
  logic       pll_rst;
  logic       sys_rst_n;
  logic       ready;
  logic       fail;
  logic [3:0] retry_cnt;
`ifdef APLL_LOSS_CNT_EN
  logic [7:0] loss_cnt;
`endif

  int n_checks = 0;
  int n_fail = 0;

  apll_reset_seq #(
    .RST_CYCLES(RST_CYCLES), .LOCK_TIMEOUT(LOCK_TIMEOUT), .STABLE_CYCLES(STABLE_CYCLES),
    .MAX_RETRY(MAX_RETRY), .CW(8)
  ) dut (
    .refclk(refclk), .rst_n(rst_n), .pll_locked(pll_locked), .soft_rst(soft_rst),
    .pll_rst(pll_rst), .sys_rst_n(sys_rst_n), .ready(ready), .fail(fail),
    .retry_cnt(retry_cnt)
`ifdef APLL_LOSS_CNT_EN
    , .loss_cnt(loss_cnt)
`endif
  );

  always #5 refclk = ~refclk;

  // Reference model: phase of the sequence, cycles spent in it, lock seen through a 2-deep delay line.
  localparam int PH_RESET = 0, PH_WAIT = 1, PH_STAB = 2, PH_RUN = 3, PH_FAIL = 4;
  int m_phase = PH_RESET;
  int m_el = 0;
  int m_retries = 0;
  int m_loss = 0;
  bit m_failed = 1'b0;
  bit m_lkq[$] = '{1'b0, 1'b0};

  task automatic model_step(input bit rn, input bit lock_in, input bit srst);
    bit seen;
    if (!rn) begin
      m_lkq = '{1'b0, 1'b0};
      m_phase = PH_RESET; m_el = 0; m_retries = 0; m_failed = 1'b0; m_loss = 0;
      return;
    end
    seen = m_lkq[0];
    void'(m_lkq.pop_front());
    m_lkq.push_back(lock_in);
    if (srst) begin
      m_phase = PH_RESET; m_el = 0; m_retries = 0; m_failed = 1'b0;
      return;
    end
    case (m_phase)
      PH_RESET: if (m_el + 1 >= RST_CYCLES) begin m_phase = PH_WAIT; m_el = 0; end
                else m_el++;
      PH_WAIT: begin
        if (seen) begin m_phase = PH_STAB; m_el = 0; end
        else if (m_el + 1 >= LOCK_TIMEOUT) begin
          m_retries = (m_retries < 15) ? m_retries + 1 : 15;
          m_el = 0;
          if (m_retries == MAX_RETRY) begin m_phase = PH_FAIL; m_failed = 1'b1; end
          else m_phase = PH_RESET;
        end else m_el++;
      end
      PH_STAB: begin
        if (!seen) begin m_phase = PH_WAIT; m_el = 0; end
        else if (m_el + 1 >= STABLE_CYCLES) begin m_phase = PH_RUN; m_el = 0; m_retries = 0; end
        else m_el++;
      end
      PH_RUN: if (!seen) begin
        m_phase = PH_RESET; m_el = 0;
        m_loss = (m_loss < 255) ? m_loss + 1 : 255;
      end
      default: ;
    endcase
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_model();
    chk("model_pll_rst", 32'(pll_rst), 32'(m_phase == PH_RESET));
    chk("model_sys_rst_n", 32'(sys_rst_n), 32'(m_phase == PH_RUN));
    chk("model_ready", 32'(ready), 32'(m_phase == PH_RUN));
    chk("model_fail", 32'(fail), 32'(m_failed));
    chk("model_retry_cnt", 32'(retry_cnt), 32'(m_retries));
`ifdef APLL_LOSS_CNT_EN
    chk("model_loss_cnt", 32'(loss_cnt), 32'(m_loss));
`endif
  endtask

  // One refclk cycle: drive on the falling edge, advance the model on the rising edge, compare 1 time unit later.
  task automatic cyc(input bit rn, input bit lk, input bit sr);
    @(negedge refclk);
    rst_n = rn; pll_locked = lk; soft_rst = sr;
    @(posedge refclk);
    model_step(rn, lk, sr);
    #1;
    check_model();
  endtask

  typedef struct {
    bit rn; bit lock;
    bit e_pll_rst; bit e_ready; bit e_fail; logic [3:0] e_retry;
  } vec_t;

  vec_t vecs[18];

  initial begin
    int cnt;
    int pulses;
    bit prev_pll;
    bit lk;
    bit sr;
    bit rn;

    // Release from reset, lock appears as WAIT_LOCK is entered: pll_rst for 4 edges, RUN after 15.
    vecs[0] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0};
    vecs[1] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0};
    for (int e = 1; e <= 16; e++)
      vecs[e + 1] = '{1'b1, (e >= 5), (e <= 3), (e >= 15), 1'b0, 4'd0};
    for (int i = 0; i < 18; i++) begin
      cyc(vecs[i].rn, vecs[i].lock, 1'b0);
      chk($sformatf("tbl%0d_pll_rst", i), 32'(pll_rst), 32'(vecs[i].e_pll_rst));
      chk($sformatf("tbl%0d_ready", i), 32'(ready), 32'(vecs[i].e_ready));
      chk($sformatf("tbl%0d_sys_rst_n", i), 32'(sys_rst_n), 32'(vecs[i].e_ready));
      chk($sformatf("tbl%0d_fail", i), 32'(fail), 32'(vecs[i].e_fail));
      chk($sformatf("tbl%0d_retry", i), 32'(retry_cnt), 32'(vecs[i].e_retry));
    end

    // One-cycle lock glitch seen in STABLE at cnt=5: full requalify, RUN at edge 22 instead of 15.
    cyc(1'b0, 1'b0, 1'b0);
    for (int e = 1; e <= 22; e++) begin
      cyc(1'b1, (e >= 5) && (e != 11), 1'b0);
      if (e == 13) chk("glitch_retry_unchanged", 32'(retry_cnt), 32'd0);
      if (e == 21) chk("glitch_not_ready_e21", 32'(ready), 32'd0);
      if (e == 22) chk("glitch_ready_e22", 32'(ready), 32'd1);
    end

    // Lock never arrives: three pll_rst pulses, then FAIL after 3 x (4 + 16) edges.
    cyc(1'b0, 1'b0, 1'b0);
    cnt = 0; pulses = 1; prev_pll = 1'b1;
    while (!fail && cnt < 200) begin
      cyc(1'b1, 1'b0, 1'b0);
      cnt++;
      if (pll_rst && !prev_pll) pulses++;
      prev_pll = pll_rst;
    end
    chk("timeout_fail_reached", 32'(fail), 32'd1);
    chk("timeout_edges", 32'(cnt), 32'd60);
    chk("timeout_pulses", 32'(pulses), 32'd3);
    chk("timeout_retry_cnt", 32'(retry_cnt), 32'd3);
    chk("timeout_pll_rst_low", 32'(pll_rst), 32'd0);
    repeat (5) cyc(1'b1, 1'b0, 1'b0);
    chk("fail_sticky", 32'(fail), 32'd1);

    // soft_rst out of FAIL with lock present: cleared at once, RUN 13 edges later.
    cyc(1'b1, 1'b1, 1'b1);
    chk("soft_fail_cleared", 32'(fail), 32'd0);
    chk("soft_retry_cleared", 32'(retry_cnt), 32'd0);
    chk("soft_pll_rst", 32'(pll_rst), 32'd1);
    cnt = 0;
    while (!ready && cnt < 100) begin
      cyc(1'b1, 1'b1, 1'b0);
      cnt++;
    end
    chk("soft_run_edges", 32'(cnt), 32'd13);

    // Lock drop in RUN: ready/sys_rst_n fall and pll_rst rises on the third edge.
    cyc(1'b1, 1'b0, 1'b0);
    chk("drop_ready_d1", 32'(ready), 32'd1);
    cyc(1'b1, 1'b0, 1'b0);
    chk("drop_ready_d2", 32'(ready), 32'd1);
    cyc(1'b1, 1'b0, 1'b0);
    chk("drop_ready_d3", 32'(ready), 32'd0);
    chk("drop_sys_rst_n_d3", 32'(sys_rst_n), 32'd0);
    chk("drop_pll_rst_d3", 32'(pll_rst), 32'd1);
`ifdef APLL_LOSS_CNT_EN
    chk("drop_loss_cnt", 32'(loss_cnt), 32'd1);
`endif

    // Back to RUN, then soft_rst on the same edge the synced lock falls: one PLL_RST entry, no loss count.
    cnt = 0;
    while (!ready && cnt < 100) begin
      cyc(1'b1, 1'b1, 1'b0);
      cnt++;
    end
    chk("rerun_reached", 32'(ready), 32'd1);
    cyc(1'b1, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b1);
    chk("both_pll_rst", 32'(pll_rst), 32'd1);
    chk("both_ready", 32'(ready), 32'd0);
    for (int e = 1; e <= 4; e++) begin
      cyc(1'b1, 1'b0, 1'b0);
      chk($sformatf("both_pll_rst_e%0d", e), 32'(pll_rst), 32'(e <= 3));
    end
`ifdef APLL_LOSS_CNT_EN
    chk("both_loss_cnt", 32'(loss_cnt), 32'd1);
`endif

    // rst_n mid-STABLE (after one timeout): next edge shows every output at its reset value.
    cyc(1'b0, 1'b0, 1'b0);
    for (int e = 1; e <= 20; e++) cyc(1'b1, 1'b0, 1'b0);
    chk("pre_reset_retry", 32'(retry_cnt), 32'd1);
    for (int e = 1; e <= 6; e++) cyc(1'b1, 1'b1, 1'b0);
    cyc(1'b0, 1'b1, 1'b0);
    chk("midrst_pll_rst", 32'(pll_rst), 32'd1);
    chk("midrst_sys_rst_n", 32'(sys_rst_n), 32'd0);
    chk("midrst_ready", 32'(ready), 32'd0);
    chk("midrst_fail", 32'(fail), 32'd0);
    chk("midrst_retry", 32'(retry_cnt), 32'd0);

    // Random stimulus against the model.
    lk = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 39) == 0) lk = ~lk;
      sr = ($urandom_range(0, 199) == 0);
      rn = ($urandom_range(0, 499) != 0);
      cyc(rn, lk, sr);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

endmodule
